pill_score_tracker: RTL and testbench

- Downstream consumer of the Pac-Man move/collision path.
- Takes the per-move collision object code from the sprite location controller, qualified by the move-done strobe.
- Maintains a 4-digit BCD score, a remaining-pill down-counter and a sticky level-clear flag.
- Drives four active-low 7-segment digits and feeds the top-level game FSM (resume/over/next-level decisions).

---
 rtl/pacman_pkg.sv | 21 ++
 rtl/bcd_sat_adder.sv | 33 +++
 rtl/hexto7segment.sv | 33 +++
 rtl/pill_score_tracker.sv | 132 +++++++++++++
 tb/tb_pill_score_tracker.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pacman_pkg.sv
// Shared Pac-Man map object codes, game-progress state and BCD score type.
package pacman_pkg;

    localparam int unsigned OBJ_W = 4;

    localparam logic [OBJ_W-1:0] OBJ_EMPTY  = 4'h0;
    localparam logic [OBJ_W-1:0] OBJ_WALL   = 4'h1;
    localparam logic [OBJ_W-1:0] OBJ_PILL   = 4'h2;
    localparam logic [OBJ_W-1:0] OBJ_POWER  = 4'h3;
    localparam logic [OBJ_W-1:0] OBJ_PACMAN = 4'h4;
    localparam logic [OBJ_W-1:0] OBJ_GHOST  = 4'h5;

    typedef enum logic {
        PLAYING = 1'b0,
        CLEARED = 1'b1
    } level_state_e;

    // Index 3 is the thousands digit, so the packed layout matches score_bcd[15:12].
    typedef logic [3:0][3:0] bcd4_t;

endpackage

// File: rtl/bcd_sat_adder.sv
// Adds a single BCD digit to a 4-digit BCD value with decimal carry, saturating at 9999.
module bcd_sat_adder
    import pacman_pkg::*;
(
    input  bcd4_t      a,
    input  logic [3:0] addend,
    output bcd4_t      sum
);

    logic       carry;
    logic [4:0] digit_raw;

    always_comb begin
        sum       = '0;
        carry     = 1'b0;
        digit_raw = '0;
        for (int i = 0; i < 4; i++) begin
            digit_raw = 5'(a[i]) + 5'((i == 0) ? addend : 4'd0) + 5'(carry);
            if (digit_raw > 5'd9) begin
                sum[i] = 4'(digit_raw - 5'd10);
                carry  = 1'b1;
            end else begin
                sum[i] = digit_raw[3:0];
                carry  = 1'b0;
            end
        end
        // Carry out of the thousands digit means the true result passed 9999.
        if (carry) begin
            sum = {4{4'd9}};
        end
    end

endmodule

// File: rtl/hexto7segment.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}; blank when disabled.
module hexto7segment (
    input  logic [3:0] hex,
    input  logic       enable,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        if (enable) begin
            unique case (hex)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                4'hF: seg = 7'h0E;
                default: seg = 7'h7F;
            endcase
        end
    end

endmodule

// File: rtl/pill_score_tracker.sv
// Pill/score bookkeeping for Pac-Man: BCD score, pill down-counter, sticky level clear.
// Optional blinking of the cleared-level score display under PILL_SCORE_BLINK_EN.
module pill_score_tracker
    import pacman_pkg::*;
#(
    parameter int unsigned TOTAL_PILLS  = 300,
    parameter int unsigned PILL_POINTS  = 1,
    parameter int unsigned POWER_POINTS = 5,
    parameter int unsigned BLINK_DIV    = 12500000
) (
    input  logic                               CLOCK_50,
    input  logic                               reset,
    input  logic                               move_done,
    input  logic [3:0]                         collision_type,
    output logic [$clog2(TOTAL_PILLS+1)-1:0]   pills_left,
    output logic [15:0]                        score_bcd,
    output logic                               pill_eaten,
    output logic                               level_clear,
    output logic [6:0]                         hex3,
    output logic [6:0]                         hex2,
    output logic [6:0]                         hex1,
    output logic [6:0]                         hex0
);

    localparam int unsigned PW = $clog2(TOTAL_PILLS + 1);

    level_state_e    state_q, state_d;
    bcd4_t           score_q, score_d;
    logic [PW-1:0]   pills_q, pills_d;
    logic            pill_eaten_q, pill_eaten_d;

    logic            is_pill_obj;
    logic            accept;
    logic [3:0]      points;
    bcd4_t           score_sum;
    logic            blink_off;
    logic [3:0][6:0] seg;

    assign is_pill_obj = (collision_type == OBJ_PILL) || (collision_type == OBJ_POWER);
    assign accept      = move_done && (state_q == PLAYING) && is_pill_obj && (pills_q != '0);
    assign points      = (collision_type == OBJ_POWER) ? 4'(POWER_POINTS) : 4'(PILL_POINTS);

    bcd_sat_adder u_adder (
        .a      (score_q),
        .addend (points),
        .sum    (score_sum)
    );

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        pills_d      = pills_q;
        pill_eaten_d = 1'b0;
        if (accept) begin
            score_d      = score_sum;
            pills_d      = pills_q - PW'(1);
            pill_eaten_d = 1'b1;
            if (pills_q == PW'(1)) begin
                state_d = CLEARED;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= PLAYING;
            score_q      <= '0;
            pills_q      <= PW'(TOTAL_PILLS);
            pill_eaten_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            pills_q      <= pills_d;
            pill_eaten_q <= pill_eaten_d;
        end
    end

`ifdef PILL_SCORE_BLINK_EN
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_off_q, blink_off_d;

    // Held at zero/on while playing, so entry to CLEARED always starts a fresh on phase.
    always_comb begin
        blink_cnt_d = '0;
        blink_off_d = 1'b0;
        if (state_q == CLEARED) begin
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blink_off_d = blink_off_q;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_off_q <= blink_off_d;
        end
    end

    assign blink_off = blink_off_q;
`else
    assign blink_off = 1'b0;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_seg
        hexto7segment u_seg (
            .hex    (score_q[g]),
            .enable (1'b1),
            .seg    (seg[g])
        );
    end

    assign hex3 = blink_off ? 7'h7F : seg[3];
    assign hex2 = blink_off ? 7'h7F : seg[2];
    assign hex1 = blink_off ? 7'h7F : seg[1];
    assign hex0 = blink_off ? 7'h7F : seg[0];

    assign pills_left  = pills_q;
    assign score_bcd   = score_q;
    assign pill_eaten  = pill_eaten_q;
    assign level_clear = (state_q == CLEARED);

endmodule

// File: tb/tb_pill_score_tracker.sv
// Directed self-checking bench for pill_score_tracker (three parameterisations side by side).
module tb_pill_score_tracker;

    localparam int unsigned PA = 300;
    localparam int unsigned PB = 20000;
    localparam int unsigned PC = 3;
    localparam int unsigned WA = $clog2(PA + 1);
    localparam int unsigned WB = $clog2(PB + 1);
    localparam int unsigned WC = $clog2(PC + 1);

    localparam logic [3:0] C_EMPTY = 4'h0;
    localparam logic [3:0] C_WALL  = 4'h1;
    localparam logic [3:0] C_PILL  = 4'h2;
    localparam logic [3:0] C_POWER = 4'h3;
    localparam logic [3:0] C_GHOST = 4'h5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] ct = 4'h0;
    logic md_a = 1'b0, md_b = 1'b0, md_c = 1'b0;

    logic [WA-1:0] pl_a;
    logic [WB-1:0] pl_b;
    logic [WC-1:0] pl_c;
    logic [15:0] sc_a, sc_b, sc_c;
    logic pe_a, pe_b, pe_c, lc_a, lc_b, lc_c;
    logic [6:0] h3_a, h2_a, h1_a, h0_a;
    logic [6:0] h3_b, h2_b, h1_b, h0_b;
    logic [6:0] h3_c, h2_c, h1_c, h0_c;

    int n_total = 0;
    int n_pass  = 0;
    int rise_a = 0, high_a = 0, high_b = 0, high_c = 0;
    logic prev_a = 1'b0;

    always #10 clk = ~clk;

    pill_score_tracker #(.TOTAL_PILLS(PA)) u_a (
        .CLOCK_50(clk), .reset(rst), .move_done(md_a), .collision_type(ct),
        .pills_left(pl_a), .score_bcd(sc_a), .pill_eaten(pe_a), .level_clear(lc_a),
        .hex3(h3_a), .hex2(h2_a), .hex1(h1_a), .hex0(h0_a));

    pill_score_tracker #(.TOTAL_PILLS(PB)) u_b (
        .CLOCK_50(clk), .reset(rst), .move_done(md_b), .collision_type(ct),
        .pills_left(pl_b), .score_bcd(sc_b), .pill_eaten(pe_b), .level_clear(lc_b),
        .hex3(h3_b), .hex2(h2_b), .hex1(h1_b), .hex0(h0_b));

    pill_score_tracker #(.TOTAL_PILLS(PC), .BLINK_DIV(4)) u_c (
        .CLOCK_50(clk), .reset(rst), .move_done(md_c), .collision_type(ct),
        .pills_left(pl_c), .score_bcd(sc_c), .pill_eaten(pe_c), .level_clear(lc_c),
        .hex3(h3_c), .hex2(h2_c), .hex1(h1_c), .hex0(h0_c));

    // Pulse bookkeeping sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (pe_a === 1'b1) high_a <= high_a + 1;
        if (pe_a === 1'b1 && prev_a !== 1'b1) rise_a <= rise_a + 1;
        prev_a <= pe_a;
        if (pe_b === 1'b1) high_b <= high_b + 1;
        if (pe_c === 1'b1) high_c <= high_c + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One strobe then one quiet cycle; outputs are settled at return.
    task automatic strobe(input int which, input logic [3:0] code);
        @(negedge clk);
        ct = code;
        if (which == 0) md_a = 1'b1;
        if (which == 1) md_b = 1'b1;
        if (which == 2) md_c = 1'b1;
        @(negedge clk);
        md_a = 1'b0;
        md_b = 1'b0;
        md_c = 1'b0;
    endtask

    logic [6:0] samp [0:31];
    int         k;

    initial begin
        // Reset then idle
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(10);
        check("rst_score_a", 32'(sc_a), 32'h0000);
        check("rst_pills_a", 32'(pl_a), 32'd300);
        check("rst_lc_a", 32'(lc_a), 32'd0);
        check("rst_pe_a", 32'(pe_a), 32'd0);
        check("rst_hex_a", {4'h0, h3_a, h2_a, h1_a, h0_a}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});
        check("rst_pills_b", 32'(pl_b), 32'd20000);
        check("rst_pills_c", 32'(pl_c), 32'd3);

        // Twelve separated normal pills
        for (int i = 0; i < 12; i++) strobe(0, C_PILL);
        idle(2);
        check("pill12_score", 32'(sc_a), 32'h0012);
        check("pill12_pills", 32'(pl_a), 32'd288);
        check("pill12_pulses", 32'(rise_a), 32'd12);
        check("pill12_pe_cycles", 32'(high_a), 32'd12);
        check("pill12_hex", {4'h0, h3_a, h2_a, h1_a, h0_a}, {4'h0, 7'h40, 7'h40, 7'h79, 7'h24});

        // Non-pill objects are ignored
        strobe(0, C_GHOST);
        strobe(0, C_EMPTY);
        strobe(0, C_WALL);
        idle(1);
        check("ignore_score", 32'(sc_a), 32'h0012);
        check("ignore_pills", 32'(pl_a), 32'd288);
        check("ignore_pulses", 32'(rise_a), 32'd12);

        // Pill code without strobe
        ct = C_PILL;
        idle(50);
        check("nostrobe_score", 32'(sc_a), 32'h0012);
        check("nostrobe_pills", 32'(pl_a), 32'd288);

        // 9997 back-to-back pills, then power pill saturates
        @(negedge clk);
        ct   = C_PILL;
        md_b = 1'b1;
        idle(9997);
        md_b = 1'b0;
        idle(1);
        check("b2b_score", 32'(sc_b), 32'h9997);
        check("b2b_pills", 32'(pl_b), 32'd10003);
        check("b2b_pe_cycles", 32'(high_b), 32'd9997);
        strobe(1, C_POWER);
        check("sat_score", 32'(sc_b), 32'h9999);
        check("sat_pills", 32'(pl_b), 32'd10002);
        check("sat_hex", {4'h0, h3_b, h2_b, h1_b, h0_b}, {4'h0, 7'h10, 7'h10, 7'h10, 7'h10});
        strobe(1, C_PILL);
        check("sat_hold_score", 32'(sc_b), 32'h9999);
        check("sat_hold_pills", 32'(pl_b), 32'd10001);

        // Small map: PILL, GHOST, POWER, PILL clears the level
        strobe(2, C_PILL);
        check("c1_score", 32'(sc_c), 32'h0001);
        check("c1_pills", 32'(pl_c), 32'd2);
        strobe(2, C_GHOST);
        check("c2_score", 32'(sc_c), 32'h0001);
        strobe(2, C_POWER);
        check("c3_score", 32'(sc_c), 32'h0006);
        check("c3_lc", 32'(lc_c), 32'd0);
        strobe(2, C_PILL);
        check("c4_score", 32'(sc_c), 32'h0007);
        check("c4_pills", 32'(pl_c), 32'd0);
        check("c4_lc", 32'(lc_c), 32'd1);
        idle(1);
        check("c4_pe_cycles", 32'(high_c), 32'd3);
        strobe(2, C_PILL);
        idle(1);
        check("frozen_score", 32'(sc_c), 32'h0007);
        check("frozen_pills", 32'(pl_c), 32'd0);
        check("frozen_pe_cycles", 32'(high_c), 32'd3);
        check("frozen_lc", 32'(lc_c), 32'd1);

        // Display while cleared
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            samp[i] = h0_c;
        end
`ifdef PILL_SCORE_BLINK_EN
        k = 1;
        while (k < 8 && samp[k] === samp[k-1]) k++;
        check("blink_edge_found", 32'(k < 8), 32'd1);
        check("blink_pair", 32'((samp[k] ^ samp[k-1]) | {6'h0, 1'b0}), 32'(7'h78 ^ 7'h7F));
        for (int grp = 0; grp < 4; grp++) begin
            logic ok;
            ok = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (samp[k + grp*4 + j] !== ((grp % 2 == 0) ? samp[k] : samp[k-1])) ok = 1'b0;
            end
            check($sformatf("blink_group%0d", grp), 32'(ok), 32'd1);
        end
`else
        k = 0;
        for (int i = 0; i < 32; i++) if (samp[i] !== 7'h78) k++;
        check("steady_hex0_c", 32'(k), 32'd0);
        check("steady_hex_c", {4'h0, h3_c, h2_c, h1_c, h0_c}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h78});
`endif

        // Strobe coincident with reset is lost
        @(negedge clk);
        rst  = 1'b1;
        ct   = C_PILL;
        md_a = 1'b1;
        md_c = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        md_a = 1'b0;
        md_c = 1'b0;
        idle(1);
        check("rststb_score_a", 32'(sc_a), 32'h0000);
        check("rststb_pills_a", 32'(pl_a), 32'd300);
        check("rststb_pe_a", 32'(pe_a), 32'd0);
        check("rststb_lc_c", 32'(lc_c), 32'd0);
        check("rststb_pills_c", 32'(pl_c), 32'd3);
        check("rststb_hex_c", {4'h0, h3_c, h2_c, h1_c, h0_c}, {4'h0, 7'h40, 7'h40, 7'h40, 7'h40});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
